cpu_core: RTL and testbench

Parametrised successor to the 8-bit breadboard CPU top level. Registers A, B, Z, IR, PC and the flags live inside one synchronous core. Memory is external, on a req/ack port that tolerates wait states, so the core can attach to RAM or ROM of any latency. Compared with the 8-bit design, the core adds:
- configurable data and address widths;
- carry and zero flags;
- subtract, store and immediate-load instructions;
- conditional jumps;
- a sticky halt state.

---
 rtl/cpu_core_if.sv | 15 +
 rtl/cpu_core.sv | 179 +++++++++++++++++
 tb/tb_cpu_core.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_if.sv
// Memory request/acknowledge bus between cpu_core and an external RAM/ROM with wait states.
interface cpu_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/ARG/MEM/HALT sequencer with A, B, IR, PC, Z and
// carry/zero flags; memory is reached over a req/ack bus that may insert wait states.
module cpu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_core_if.master        mem,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted
);
    localparam int unsigned SUM_W = DATA_W + 1;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_LDB = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_STA = 4'd5;
    localparam logic [3:0] OP_OUT = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_JC  = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ARG,
        S_MEM,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              req_q, req_d;
    logic              we_q, we_d;

    logic              done_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] arg_addr_c;
    logic [SUM_W-1:0]  sum_c;

    assign done_c     = req_q & mem.mem_ack;
    assign pc_inc_c   = pc_q + ADDR_W'(1);
    assign arg_addr_c = mem.mem_rdata[ADDR_W-1:0];
    // SUB is A + ~B + 1, so its carry-out reads as "no borrow"
    assign sum_c = (ir_q == OP_SUB)
                 ? ({1'b0, a_q} + {1'b0, ~b_q} + SUM_W'(1))
                 : ({1'b0, a_q} + {1'b0, b_q});

    // Sequencer and datapath next-state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_data_d  = out_data_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;

        unique case (state_q)
            S_FETCH: begin
                if (done_c) begin
                    ir_d    = mem.mem_rdata[3:0];
                    pc_d    = pc_inc_c;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (ir_q)
                    OP_ADD, OP_SUB: begin
                        a_d  = sum_c[DATA_W-1:0];
                        cf_d = sum_c[DATA_W];
                        zf_d = (sum_c[DATA_W-1:0] == '0);
                    end
                    OP_OUT: begin
                        out_data_d  = a_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    OP_LDA, OP_LDB, OP_STA, OP_JMP, OP_JZ, OP_JC, OP_LDI: state_d = S_ARG;
                    default: ;
                endcase
            end
            S_ARG: begin
                if (done_c) begin
                    pc_d    = pc_inc_c;
                    state_d = S_FETCH;
                    case (ir_q)
                        OP_JMP: pc_d = arg_addr_c;
                        OP_JZ:  if (zf_q) pc_d = arg_addr_c;
                        OP_JC:  if (cf_q) pc_d = arg_addr_c;
                        OP_LDI: a_d = mem.mem_rdata;
                        OP_LDA, OP_LDB, OP_STA: begin
                            state_d = S_MEM;
                            addr_d  = arg_addr_c;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (done_c) begin
                    if (ir_q == OP_LDA) a_d = mem.mem_rdata;
                    if (ir_q == OP_LDB) b_d = mem.mem_rdata;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        // Bus outputs are registered from the state being entered; addr_q doubles as Z in MEM
        if (state_d != S_MEM) addr_d = pc_d;
        req_d = (state_d == S_FETCH) || (state_d == S_ARG) || (state_d == S_MEM);
        we_d  = (state_d == S_MEM) && (ir_d == OP_STA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            addr_q      <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            req_q       <= 1'b1;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_data_q  <= out_data_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            req_q       <= req_d;
            we_q        <= we_d;
        end
    end

    // req_q resets high so FETCH is requested in the very first cycle; reset masks it meanwhile
    assign mem.mem_req   = req_q & reset;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = a_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: directed programs plus random programs checked against an
// instruction-level reference model, with zero-wait, random and scripted memory wait states.
module tb_cpu_core;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;

    cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .mem(bus),
        .out_data(out_data), .out_valid(out_valid), .halted(halted)
    );

    // Second core with a narrow PC and wide words
    logic        reset12;
    logic [11:0] out_data12;
    logic        out_valid12;
    logic        halted12;
    logic [11:0] img12 [16];
    cpu_core_if #(.DATA_W(12), .ADDR_W(4)) bus12 ();
    cpu_core #(.DATA_W(12), .ADDR_W(4)) dut12 (
        .clk(clk), .reset(reset12), .mem(bus12),
        .out_data(out_data12), .out_valid(out_valid12), .halted(halted12)
    );
    assign bus12.mem_rdata = img12[bus12.mem_addr];
    assign bus12.mem_ack   = 1'b1;

    logic [7:0] img [256];
    logic [7:0] mem [256];
    logic [7:0] model_mem [256];
    int         exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ack_mode = 0;
    logic [3:0] op_tab [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8,
                                4'd9, 4'd10, 4'd6, 4'd3, 4'd4, 4'd7, 4'd12};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: reloaded from the program image while reset is held, otherwise takes stores
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (!reset) mem <= img;
        else if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Ack generator: 0 zero-wait, 1 random waits, 2 three waits per store, 3 never ack >=0x80
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack = 1'b1;
        forever begin
            @(negedge clk);
            case (ack_mode)
                1: bus.mem_ack = ($urandom_range(0, 2) != 0);
                2: begin
                    if (bus.mem_req && bus.mem_we) begin
                        bus.mem_ack = (wcnt == 3);
                        wcnt++;
                    end else begin
                        bus.mem_ack = 1'b1;
                        wcnt = 0;
                    end
                end
                3: bus.mem_ack = !(bus.mem_req && bus.mem_addr >= 8'h80);
                default: bus.mem_ack = 1'b1;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: every OUT pulse must match the oldest expected value
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got out_data=%0d, required no OUT", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Instruction-level reference: runs img to HLT, queues OUT values, leaves final memory
    task automatic model_run();
        logic [7:0] m [256];
        logic [7:0] a, b, pc, arg, op;
        logic       zf, cf;
        int         s;
        m = img; a = 0; b = 0; pc = 0; zf = 0; cf = 0;
        for (int step = 0; step < 5000; step++) begin
            op  = {4'h0, m[pc][3:0]};
            arg = m[pc + 8'd1];
            pc  = (op inside {8'd1, 8'd2, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10}) ? pc + 8'd2 : pc + 8'd1;
            if (op == 8'd15) break;
            case (op)
                8'd1:  a = m[arg];
                8'd2:  b = m[arg];
                8'd3:  begin s = a + b; cf = (s > 255); a = 8'(s); zf = (a == 0); end
                8'd4:  begin cf = (a >= b); a = a - b; zf = (a == 0); end
                8'd5:  m[arg] = a;
                8'd6:  exp_q.push_back(int'(a));
                8'd7:  pc = arg;
                8'd8:  if (zf) pc = arg;
                8'd9:  if (cf) pc = arg;
                8'd10: a = arg;
                default: ;
            endcase
        end
        model_mem = m;
    endtask

    // Random program with forward-only jumps to instruction boundaries, ending in HLT
    task automatic gen_random();
        int         starts [$];
        int         jargs [$];
        int         pc;
        int         j;
        logic [3:0] op;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        pc = 0;
        while (pc < 96) begin
            starts.push_back(pc);
            op = op_tab[$urandom_range(0, 13)];
            img[pc] = {4'($urandom), op};
            if (op inside {4'd1, 4'd2, 4'd5}) img[pc+1] = 8'($urandom_range(192, 255));
            if (op inside {4'd7, 4'd8, 4'd9}) jargs.push_back(pc + 1);
            pc += (op inside {4'd1, 4'd2, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10}) ? 2 : 1;
        end
        starts.push_back(pc);
        img[pc] = {4'($urandom), 4'hF};
        foreach (jargs[k]) begin
            j = 0;
            while (starts[j] != jargs[k] - 1) j++;
            img[jargs[k]] = 8'(starts[$urandom_range(j + 1, starts.size() - 1)]);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_dut(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_first_req"}, bus.mem_req, 1);
        check({tag, "_first_addr"}, bus.mem_addr, 0);
        check({tag, "_first_we"}, bus.mem_we, 0);
    endtask

    task automatic wait_halt(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (halted !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got halted=%b after %0d cycles, required 1", tag, halted, cyc);
        end
        repeat (3) @(negedge clk);
        check({tag, "_req_after_halt"}, bus.mem_req, 0);
        check({tag, "_halt_sticky"}, halted, 1);
        check({tag, "_outs_pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_bus(input string tag, input logic [7:0] addr, input logic we);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.mem_req && bus.mem_addr == addr && bus.mem_we == we) && cyc < 100);
        check({tag, "_bus_seen"}, bus.mem_req && bus.mem_addr == addr && bus.mem_we == we, 1);
    endtask

    initial begin
        int cyc;
        int errs;
        int wraps;
        logic [3:0] exp_pc;
        logic [3:0] nop_tab [5];
        nop_tab = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14};
        reset   = 1'b0;
        reset12 = 1'b0;
        clear_img();
        repeat (2) @(negedge clk);
        check("reset_req", bus.mem_req, 0);
        check("reset_valid", out_valid, 0);
        check("reset_halted", halted, 0);
        check("reset_out_data", out_data, 0);

        // LDI 5; OUT; HLT
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h05; img[2] = 8'h06; img[3] = 8'h0F;
        ack_mode = 0;
        exp_q.push_back(5);
        hold_reset();
        release_dut("p1");
        wait_halt("p1", 50, cyc);
        check("p1_halt_cycles", cyc, 7);

        // 200 + 100 wraps to 44 with carry; JC taken to a second OUT
        clear_img();
        img[0] = 8'h01; img[1] = 8'h80; img[2] = 8'h02; img[3] = 8'h81; img[4] = 8'h03;
        img[5] = 8'h06; img[6] = 8'h09; img[7] = 8'h0A; img[8] = 8'h0F; img[9] = 8'h0F;
        img[10] = 8'h06; img[11] = 8'h0F; img[8'h80] = 8'd200; img[8'h81] = 8'd100;
        exp_q.push_back(44); exp_q.push_back(44);
        hold_reset();
        release_dut("p2");
        wait_halt("p2", 100, cyc);

        // Count-down loop under random wait states
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h03; img[2] = 8'h02; img[3] = 8'h80; img[4] = 8'h04;
        img[5] = 8'h06; img[6] = 8'h08; img[7] = 8'h0B; img[8] = 8'h07; img[9] = 8'h04;
        img[11] = 8'h0F; img[8'h80] = 8'd1;
        ack_mode = 1;
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        hold_reset();
        release_dut("p3");
        wait_halt("p3", 400, cyc);

        // STA 0x90 with three wait states: bus must hold for four cycles
        clear_img();
        img[0] = 8'h0A; img[1] = 8'hA5; img[2] = 8'h05; img[3] = 8'h90; img[4] = 8'h0F;
        ack_mode = 2;
        hold_reset();
        release_dut("sta");
        wait_bus("sta", 8'h90, 1'b1);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(bus.mem_req && bus.mem_we && bus.mem_addr == 8'h90 && bus.mem_wdata == 8'hA5))
                errs++;
            @(negedge clk);
        end
        check("sta_hold_errs", errs, 0);
        check("sta_next_req", bus.mem_req, 1);
        check("sta_next_we", bus.mem_we, 0);
        check("sta_next_addr", bus.mem_addr, 4);
        wait_halt("sta", 50, cyc);
        check("sta_mem", mem[8'h90], 8'hA5);

        // Reset during a stalled LDA: request dropped, A not loaded, restart at 0
        clear_img();
        img[0] = 8'h06; img[1] = 8'h01; img[2] = 8'h80; img[3] = 8'h06; img[4] = 8'h0F;
        img[8'h80] = 8'h3C;
        ack_mode = 3;
        exp_q.push_back(0);
        hold_reset();
        release_dut("rst");
        wait_bus("rst", 8'h80, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_stalled_req", bus.mem_req, 1);
        reset = 1'b0;
        #1;
        check("rst_req_drop", bus.mem_req, 0);
        check("rst_first_outs", exp_q.size(), 0);
        ack_mode = 0;
        exp_q.push_back(0); exp_q.push_back(8'h3C);
        repeat (2) @(negedge clk);
        release_dut("rst2");
        wait_halt("rst2", 100, cyc);

        // Random programs under random wait states against the reference model
        for (int r = 0; r < 8; r++) begin
            gen_random();
            model_run();
            ack_mode = 1;
            hold_reset();
            release_dut("rnd");
            wait_halt("rnd", 3000, cyc);
            errs = 0;
            for (int i = 8'hC0; i < 256; i++) if (mem[i] !== model_mem[i]) errs++;
            check("rnd_data_mem", errs, 0);
        end
        ack_mode = 0;

        // 12-bit words, 4-bit PC: NOPs with junk upper bits, fetch address must wrap 15 -> 0
        for (int i = 0; i < 16; i++)
            img12[i] = {8'($urandom_range(1, 255)), nop_tab[$urandom_range(0, 4)]};
        @(negedge clk);
        reset12 = 1'b1;
        #1;
        check("w12_first_req", bus12.mem_req, 1);
        check("w12_first_addr", bus12.mem_addr, 0);
        exp_pc = 4'd1;
        errs   = 0;
        wraps  = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus12.mem_req) begin
                if (bus12.mem_addr !== exp_pc) errs++;
                exp_pc = exp_pc + 4'd1;
                if (exp_pc == 4'd0) wraps++;
            end
            if (halted12 || out_valid12) errs++;
        end
        check("w12_addr_errs", errs, 0);
        check("w12_wraps", wraps, 2);
        check("w12_out_data", out_data12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
